// File: rtl/iic_send_scheduler.sv
// Round-robin scheduler sharing one iic_send write engine between NUM_REQ requesters.
// Build option: define IIC_SCHED_PRIO0_EN to give requester 0 fixed top priority.
module iic_send_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int TXN_CYCLES = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [7*NUM_REQ-1:0]   req_dev_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg_addr,
    input  logic [8*NUM_REQ-1:0]   req_wr_data,
    output logic [NUM_REQ-1:0]     req_grant,
    output logic [NUM_REQ-1:0]     req_done,
    output logic                   busy,
    output logic [2:0]             cur_id,
    output logic                   iic_send_en,
    output logic [6:0]             iic_device_addr,
    output logic [7:0]             iic_send_addr,
    output logic [7:0]             iic_send_data
);

    localparam int MAX_CNT = (TXN_CYCLES > GAP_CYCLES) ? TXN_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] TXN_LAST = CNT_W'(TXN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [2:0]           rr_last_reg, rr_last_next;
    logic [2:0]           cur_id_reg, cur_id_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [NUM_REQ-1:0]   done_reg, done_next;
    logic                 busy_reg, busy_next;
    logic                 en_reg, en_next;
    logic [6:0]           dev_reg, dev_next;
    logic [7:0]           addr_reg, addr_next;
    logic [7:0]           data_reg, data_next;

    // Requester fields padded to 8 entries so a 3-bit id indexes them directly.
    logic [7:0]           valid_pad;
    logic [6:0]           dev_arr  [8];
    logic [7:0]           addr_arr [8];
    logic [7:0]           data_arr [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < NUM_REQ) begin : g_used
                assign valid_pad[gi] = req_valid[gi];
                assign dev_arr[gi]   = req_dev_addr[gi*7 +: 7];
                assign addr_arr[gi]  = req_reg_addr[gi*8 +: 8];
                assign data_arr[gi]  = req_wr_data[gi*8 +: 8];
            end else begin : g_unused
                assign valid_pad[gi] = 1'b0;
                assign dev_arr[gi]   = 7'd0;
                assign addr_arr[gi]  = 8'd0;
                assign data_arr[gi]  = 8'd0;
            end
        end
    endgenerate

    logic [7:0] rr_mask;
    logic [2:0] probe;
    logic [2:0] win_id;
    logic       win_found;
    logic       rr_update;

    always_comb begin
`ifdef IIC_SCHED_PRIO0_EN
        rr_mask = valid_pad & 8'hFE;
`else
        rr_mask = valid_pad;
`endif
    end

    // Search starts just after the last owner and wraps, giving round-robin fairness.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        probe     = 3'd0;
        rr_update = 1'b1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            probe = 3'((int'(rr_last_reg) + k) % NUM_REQ);
            if (!win_found && rr_mask[probe]) begin
                win_found = 1'b1;
                win_id    = probe;
            end
        end
`ifdef IIC_SCHED_PRIO0_EN
        if (valid_pad[0]) begin
            win_found = 1'b1;
            win_id    = 3'd0;
            rr_update = 1'b0;
        end
`endif
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rr_last_next = rr_last_reg;
        cur_id_next  = cur_id_reg;
        grant_next   = '0;
        done_next    = '0;
        busy_next    = busy_reg;
        en_next      = 1'b0;
        dev_next     = dev_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    grant_next  = NUM_REQ'(1) << win_id;
                    dev_next    = dev_arr[win_id];
                    addr_next   = addr_arr[win_id];
                    data_next   = data_arr[win_id];
                    cur_id_next = win_id;
                    if (rr_update) begin
                        rr_last_next = win_id;
                    end
                    busy_next   = 1'b1;
                    state_next  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                en_next    = 1'b1;
                cnt_next   = '0;
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                // The engine has no done flag, so its fixed transaction length is timed here.
                if (cnt_reg == TXN_LAST) begin
                    done_next = NUM_REQ'(1) << cur_id_reg;
                    cnt_next  = '0;
                    if (GAP_CYCLES == 0) begin
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_GAP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            rr_last_reg <= 3'(NUM_REQ - 1);
            cur_id_reg  <= 3'd0;
            grant_reg   <= '0;
            done_reg    <= '0;
            busy_reg    <= 1'b0;
            en_reg      <= 1'b0;
            dev_reg     <= 7'd0;
            addr_reg    <= 8'd0;
            data_reg    <= 8'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rr_last_reg <= rr_last_next;
            cur_id_reg  <= cur_id_next;
            grant_reg   <= grant_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
            en_reg      <= en_next;
            dev_reg     <= dev_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
        end
    end

    assign req_grant       = grant_reg;
    assign req_done        = done_reg;
    assign busy            = busy_reg;
    assign cur_id          = cur_id_reg;
    assign iic_send_en     = en_reg;
    assign iic_device_addr = dev_reg;
    assign iic_send_addr   = addr_reg;
    assign iic_send_data   = data_reg;

endmodule
